// File: rtl/version_report_framer.sv
// Build-stamp report framer: snapshots the version constants
// and streams a 13-byte SOF/payload/XOR frame to a UART byte sink.
module version_report_framer #(
  parameter logic [7:0] SOF_BYTE      = 8'hA5,
  parameter int         PERIOD_CYCLES = 0,
  parameter int         COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [7:0]         ver_major,
  input  logic [7:0]         ver_minor,
  input  logic [7:0]         ver_patch,
  input  logic [7:0]         ver_build,
  input  logic [15:0]        ver_year,
  input  logic [7:0]         ver_month,
  input  logic [7:0]         ver_day,
  input  logic [7:0]         ver_hour,
  input  logic [7:0]         ver_minute,
  input  logic [7:0]         ver_second,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               frame_done,
  output logic [COUNT_W-1:0] frame_count
);

  localparam int TW = (PERIOD_CYCLES > 0) ?
                      $clog2(PERIOD_CYCLES + 1) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          tick, start, hs, last;
  logic          load, advance, finish;
  logic          pending;
  logic [3:0]    idx;
  logic [7:0]    snap [12];
  logic [7:0]    chk_in;

  assign tick  = (PERIOD_CYCLES > 0) &&
                 (timer == TW'(PERIOD_CYCLES - 1));
  assign start = req | tick;
  assign hs    = tx_valid & tx_ready;
  assign last  = (idx == 4'd12);

  assign chk_in = ver_major ^ ver_minor ^ ver_patch ^
                  ver_build ^ ver_year[15:8] ^
                  ver_year[7:0] ^ ver_month ^ ver_day ^
                  ver_hour ^ ver_minute ^ ver_second;

  // Next state and the load/advance/finish strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start || pending) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (last) begin
            finish = 1'b1;
            if (pending || start) begin
              load = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Free-running period timer, independent of busy
  always_ff @(posedge clk) begin
    if (rst || PERIOD_CYCLES == 0 || tick) timer <= '0;
    else                                   timer <= timer + TW'(1);
  end

  // Snapshot payload and its checksum at frame start
  always_ff @(posedge clk) begin
    if (load) begin
      snap[0]  <= ver_major;
      snap[1]  <= ver_minor;
      snap[2]  <= ver_patch;
      snap[3]  <= ver_build;
      snap[4]  <= ver_year[15:8];
      snap[5]  <= ver_year[7:0];
      snap[6]  <= ver_month;
      snap[7]  <= ver_day;
      snap[8]  <= ver_hour;
      snap[9]  <= ver_minute;
      snap[10] <= ver_second;
      snap[11] <= chk_in;
    end
  end

  // Byte sequencing, handshake outputs and frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      pending     <= 1'b0;
      idx         <= '0;
    end else begin
      frame_done <= finish;
      if (finish) frame_count <= frame_count + 1'b1;
      if (load) begin
        idx      <= '0;
        tx_data  <= SOF_BYTE;
        tx_valid <= 1'b1;
        busy     <= 1'b1;
      end else if (advance) begin
        idx     <= idx + 1'b1;
        tx_data <= snap[idx];
      end else if (finish) begin
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end
      if (load)                        pending <= 1'b0;
      else if (state == SEND && start) pending <= 1'b1;
    end
  end

endmodule

// File: doc/version_report_framer.md
Name: version_report_framer

Overview:
- Consumes the build-stamp constants (version and build date/time, driven at top level from the version package) and turns them into a framed byte stream for the UART transmitter.
- The host can read the exact bitstream build over the serial link.
- Sits between the constant build stamp and the uart_tx byte input (valid/ready).
- Frames are sent on request or periodically.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker byte.
- PERIOD_CYCLES, 0, auto-report period in clk cycles; 0 disables periodic reports.
- COUNT_W, 16, width of frame_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  report request; level sampled each cycle; any high cycle counts as a request.
- ver_major  in  8  version major.
- ver_minor  in  8  version minor.
- ver_patch  in  8  version patch.
- ver_build  in  8  build number.
- ver_year  in  16  BCD year.
- ver_month  in  8  BCD month.
- ver_day  in  8  BCD day.
- ver_hour  in  8  BCD hour.
- ver_minute  in  8  BCD minute.
- ver_second  in  8  BCD second.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts byte.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse on final byte handshake.
- frame_count  out  COUNT_W  completed frames, wraps.

Behaviour:
- Reset values (all registered): tx_valid=0, tx_data=0, busy=0, frame_done=0, frame_count=0. Pending flag, byte index and period timer also clear to 0.
- Frame layout, 13 bytes in order:
  - SOF_BYTE
  - major, minor, patch, build
  - year[15:8], year[7:0]
  - month, day, hour, minute, second
  - CHK, the XOR of the 11 payload bytes (SOF excluded).
- State machine, two states: IDLE and SEND.
- IDLE: if the start condition holds (req, or periodic tick, or pending=1), then on the next edge:
  - snapshot all ver_* inputs into internal registers and precompute CHK from the snapshot;
  - set index=0, tx_data=SOF_BYTE, tx_valid=1, busy=1, clear pending;
  - go to SEND.
  - Latency: req high in cycle N gives tx_valid=1 with SOF in cycle N+1.
- SEND: standard valid/ready rules.
  - tx_data and tx_valid are held stable until a cycle with tx_valid&&tx_ready.
  - tx_valid never drops without a handshake.
- Handshake at index<12: index+1; tx_data is the next byte, presented the following cycle; tx_valid stays 1.
  - With tx_ready held high, one byte is sent per cycle and the frame takes 13 cycles.
- Handshake at index=12 (CHK):
  - frame_done=1 for one cycle;
  - frame_count+1, wrapping modulo 2^COUNT_W.
- After the CHK handshake:
  - If pending=1 or a new start condition holds that cycle: start a new frame immediately with a fresh snapshot. tx_valid stays 1, tx_data=SOF next cycle, busy stays 1, no idle gap.
  - Otherwise: tx_valid=0, busy=0, go to IDLE.
- Snapshot rule: ver_* changes during SEND do not affect the current frame.
- Requests while busy (req or periodic tick during SEND, excluding the final-handshake cycle): set pending=1.
  - Single-deep; further requests coalesce.
  - Exactly one extra frame follows.
- Periodic timer:
  - PERIOD_CYCLES=0: timer held at 0, tick never asserted.
  - Otherwise the timer counts 0..PERIOD_CYCLES-1 continuously, independent of busy.
  - Tick is asserted in the cycle the timer equals PERIOD_CYCLES-1; it then wraps to 0.
  - Tick and req in the same cycle count as a single request.
- Reset mid-frame: the frame is aborted with no frame_done and no count increment.
  - tx_valid=0 the cycle after rst is sampled.
  - A consumer mid-byte must tolerate the truncated frame; the host resyncs on SOF.
- Timer width: clog2(PERIOD_CYCLES+1), minimum 1.

Test Plan:
- Single frame, tx_ready=1, inputs 0,0,0,56, year 16'h2025, then 11,07,10,48,35 (hex), req pulse at cycle 10.
  - Required: tx_valid rises at cycle 11.
  - Bytes A5,00,00,00,38,20,25,11,07,10,48,35,46 on consecutive cycles.
  - frame_done pulses with the byte 46; frame_count=1; busy=0 after.
- Backpressure: tx_ready pseudo-random ~30% high.
  - Required: same 13 bytes in order.
  - tx_data and tx_valid unchanged across every stalled cycle; no byte lost or duplicated.
- Snapshot: change ver_build to 57 after the SOF handshake.
  - Required: current frame still carries 38 and CHK 46.
  - Next frame carries 39 with CHK 47.
- Coalescing: pulse req 3 times during a frame.
  - Required: exactly one extra frame, starting the cycle after the first frame's CHK handshake (no gap); frame_count=2.
- Periodic: PERIOD_CYCLES=100, tx_ready=1, req=0.
  - Required: SOF appears at cycles 100, 200, 300 after reset release (tick at timer=99, +1 latency).
  - frame_count increments by 1 per frame.
- Reset mid-frame: assert rst after the 5th byte handshake.
  - Required: tx_valid=0 the next cycle, frame_count=0, no frame_done.
  - After release with req, a complete fresh frame starting with A5.
